// File: rtl/token_run_pkg.sv
// token_run_pkg: shared run-record type and length helper for the run-length encoder.
package token_run_pkg;

    localparam int LEN_W = 8;

    typedef struct packed {
        logic             bit_val;
        logic [LEN_W-1:0] len;
    } run_rec_t;

    function automatic int max_len(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/token_run_fifo.sv
// token_run_fifo: synchronous record FIFO; simultaneous push and pop is accepted even when full.
module token_run_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic         do_push, do_pop;

    always_comb begin
        empty   = wr_q == rd_q;
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q + (AW+1)'(do_push);
        rd_d    = rd_q + (AW+1)'(do_pop);
        head    = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/token_run_encoder.sv
// token_run_encoder: compresses a serial bit stream into {bit, run length} records
// delivered through a buffered valid/ready port with a sticky drop flag.
module token_run_encoder #(
    parameter int LEN_W      = token_run_pkg::LEN_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [LEN_W-1:0] out_len,
    output logic             overflow
);
    import token_run_pkg::*;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(max_len(LEN_W));
    localparam int W = LEN_W + 1;

    logic             started_q, started_d, cur_bit_q, cur_bit_d, overflow_q, overflow_d;
    logic [LEN_W-1:0] cur_len_q, cur_len_d;
    logic [W-1:0]     last_q, last_d, head;
    logic             close, push, pop, full, empty;

    always_comb begin
        close      = flush || (a != cur_bit_q) || (cur_len_q == MAX_LEN);
        push       = started_q && close;
        pop        = !empty && out_ready;
        started_d  = 1'b1;
        cur_bit_d  = (started_q && !close) ? cur_bit_q : a;
        cur_len_d  = (started_q && !close) ? cur_len_q + 1'b1 : LEN_W'(1);
        overflow_d = overflow_q || (push && full && !pop);
        last_d     = pop ? head : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            started_q  <= 1'b0;
            cur_bit_q  <= 1'b0;
            cur_len_q  <= '0;
            overflow_q <= 1'b0;
            last_q     <= '0;
        end else begin
            started_q  <= started_d;
            cur_bit_q  <= cur_bit_d;
            cur_len_q  <= cur_len_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
        end
    end

    token_run_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data({cur_bit_q, cur_len_q}),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    // Outputs hold the last delivered record while the buffer is empty.
    assign out_valid          = !empty;
    assign {out_bit, out_len} = empty ? last_q : head;
    assign overflow           = overflow_q;

endmodule

// File: doc/token_run_encoder.md
# token_run_encoder

Serial-stream consumer placed directly downstream of the token doubler. It samples one bit of the serial stream every cycle and compresses it into run-length records. Each record is {bit value, run length}, and records are delivered through a buffered valid/ready interface to the packet and statistics logic. Runs longer than the length field can hold are split. Records lost to back-pressure raise a sticky overflow flag.

## Interface
Parameters:
- LEN_W, 8: width of the run-length field. Maximum run length per record is MAX_LEN = 2^LEN_W − 1.
- FIFO_DEPTH, 4: record buffer depth. Power of two, at least 2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- a  input  1  serial token stream, sampled every cycle.
- flush  input  1  forces the current run to close.
- out_valid  output  1  a record is available.
- out_ready  input  1  the consumer accepts the record.
- out_bit  output  1  bit value of the record.
- out_len  output  LEN_W  run length, range 1..MAX_LEN.
- overflow  output  1  sticky flag: a record was dropped.

## Operation
- Run tracker state: started, cur_bit, cur_len.
- Reset values: started=0, cur_len=0, FIFO empty, out_valid=0, out_bit=0, out_len=0, overflow=0.
- Per cycle, evaluated in priority order:
  - started==0: set started=1, cur_bit=a, cur_len=1. No push.
  - flush==1, or a!=cur_bit, or cur_len==MAX_LEN: push {cur_bit,cur_len} into the FIFO, then cur_bit=a, cur_len=1.
  - Otherwise: cur_len=cur_len+1.
- Flush closes the run accumulated before the current cycle. The bit sampled in the flush cycle starts the new run.
- A run of exactly MAX_LEN is pushed when the next bit arrives, whether that bit matches or differs.
- A longer same-bit run is split into MAX_LEN records plus a final remainder record.
- FIFO rules:
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle are both performed, including when the FIFO is full, so a record is never dropped in that case.
  - Push while full without a pop drops the new record and sets overflow=1. overflow stays 1 until rst.
  - After a drop, the tracker still restarts with the new run.
- out_bit and out_len come from the FIFO head and are held stable while out_valid && !out_ready.
- When out_valid=0, out_bit and out_len hold their last values. This is don't-care for the consumer.
- The last run is never emitted without a flush or a bit change.
- rst mid-operation discards the partial run and all buffered records, and clears overflow.

## Timing
- Push happens at the rising edge that ends cycle N, where cycle N is the first cycle with a differing bit, a flush, or a saturated run.
- The record is visible on out_valid in cycle N+1 if the FIFO was empty. There is no combinational bypass.
- Pop at an edge: the next record appears in the following cycle, so one record per cycle is sustained.
- With out_ready held at 1, steady state needs no buffering: at most 1 record per cycle enters and 1 leaves.
- overflow rises in the cycle after the dropping edge.
- Release from rst: the first sampled bit is the value of a in the first cycle with rst=0.

## Structure
- Package token_run_pkg:
  - typedef struct packed { logic bit_val; logic [LEN_W-1:0] len; } for the run record. LEN_W is a package constant defaulting to 8.
  - Function computing MAX_LEN.
- Sub-module token_run_fifo:
  - Synchronous FIFO of run records.
  - Pointers one bit wider than the address, for full/empty detection.
  - Exposes push, pop, full, empty, and head data.
- Top level holds the run tracker, the push decision and the overflow flag.

## Test plan
- Doubler example: a=11011011110111111001111110 followed by flush, out_ready=1. Required records: (1,2) (0,1) (1,2) (0,1) (1,4) (0,1) (1,6) (0,2) (1,6) (0,1), in order, each one cycle after its terminating bit.
- Saturation: 600 consecutive ones, then a=0, LEN_W=8. Required records: (1,255), (1,255), (1,90). overflow=0.
- Back-pressure: FIFO_DEPTH=4, out_ready=0, alternating 1010… stream.
  - The 5th push sets overflow. Later records are dropped.
  - After out_ready=1, exactly the first 4 records drain with stable data.
  - overflow stays 1.
- Full with simultaneous pop: FIFO full, out_ready=1 in the same cycle as a push. Required: no drop, overflow=0, ordering preserved.
- Flush corner cases:
  - flush on the first cycle after reset: no record.
  - flush with a=1 after a run of three 1s: (1,3) is pushed and a new run of length 1 starts.
  - flush on consecutive cycles: one (x,1) record per cycle.
- Reset mid-run: 5 ones, then rst for 1 cycle, then 2 ones and a 0. Required: only (1,2); overflow cleared; out_valid=0 in the cycle after rst.
